// File: rtl/instr_dispatch_if.sv
// Bundle of push, status and issue-channel signals between the control unit and instr_dispatch.
// The control side (or a testbench) uses the master modport; the dispatcher uses the slave modport.
interface instr_dispatch_if;
  logic        push_we;
  logic [1:0]  push_instr_type;
  logic [13:0] push_arith_instr;
  logic [8:0]  push_ram_instr;
  logic [9:0]  push_ld_st_instr;
  logic [17:0] push_cache_addr;
  logic [17:0] push_main_mem_addr;
  logic [17:0] push_d_cache_addr;
  logic [17:0] push_d_main_mem_addr;
  logic [3:0]  push_copies;

  logic        queue_full;
  logic        queue_empty;
  logic        overflow;
  logic        idle;

  // Each issue channel: valid/ready handshake, a transfer occurs on a clock edge where both are high;
  // once valid rises the payload holds until that transfer, and ready never depends on valid.
  logic        ldst_valid;
  logic        ldst_ready;
  logic [9:0]  ldst_instr;
  logic [17:0] ldst_cache_addr;

  logic        ram_valid;
  logic        ram_ready;
  logic [8:0]  ram_instr;
  logic [17:0] ram_cache_addr;
  logic [17:0] ram_main_mem_addr;

  logic        arith_valid;
  logic        arith_ready;
  logic [13:0] arith_instr;

  modport master (
    output push_we, push_instr_type, push_arith_instr, push_ram_instr, push_ld_st_instr,
           push_cache_addr, push_main_mem_addr, push_d_cache_addr, push_d_main_mem_addr,
           push_copies, ldst_ready, ram_ready, arith_ready,
    input  queue_full, queue_empty, overflow, idle,
           ldst_valid, ldst_instr, ldst_cache_addr,
           ram_valid, ram_instr, ram_cache_addr, ram_main_mem_addr,
           arith_valid, arith_instr
  );

  modport slave (
    input  push_we, push_instr_type, push_arith_instr, push_ram_instr, push_ld_st_instr,
           push_cache_addr, push_main_mem_addr, push_d_cache_addr, push_d_main_mem_addr,
           push_copies, ldst_ready, ram_ready, arith_ready,
    output queue_full, queue_empty, overflow, idle,
           ldst_valid, ldst_instr, ldst_cache_addr,
           ram_valid, ram_instr, ram_cache_addr, ram_main_mem_addr,
           arith_valid, arith_instr
  );
endinterface

// File: rtl/instr_dispatch.sv
// In-order instruction queue and dispatcher: FIFO of pushes, each expanded into up to MAX_COPIES issues.
// Optional macro DISPATCH_STATS_EN adds the stat_issued / stat_stall_cycles counters.
module instr_dispatch #(
  parameter int DEPTH      = 16,
  parameter int MAX_COPIES = 8
) (
  input  logic                clk,
  input  logic                reset,
  instr_dispatch_if.slave     bus,
  output logic [1:0]          dbg_state
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]         stat_issued,
  output logic [31:0]         stat_stall_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [1:0]  itype;
    logic [13:0] arith;
    logic [8:0]  ram;
    logic [9:0]  ldst;
    logic [17:0] cache;
    logic [17:0] main;
    logic [17:0] d_cache;
    logic [17:0] d_main;
    logic [3:0]  copies;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ISSUE = 2'd1
  } state_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  entry_t          push_entry;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;

  state_t          state;
  state_t          state_next;
  logic [1:0]      iss_type;
  logic [3:0]      iss_remaining;
  logic [17:0]     iss_d_cache;
  logic [17:0]     iss_d_main;

  logic            push_acc;
  logic            pop;
  logic            step;
  logic            sel_valid;
  logic            sel_ready;
  logic            handshake;

  // Copy count is normalised at push time so the issue stage only ever sees 1..MAX_COPIES.
  function automatic logic [3:0] clamp_copies(input logic [3:0] c);
    logic [3:0] r;
    if (c == 4'd0) r = 4'd1;
    else if (c > 4'(MAX_COPIES)) r = 4'(MAX_COPIES);
    else r = c;
    return r;
  endfunction

  assign push_acc = bus.push_we && !bus.queue_full && (bus.push_instr_type != 2'd3);
  assign head     = mem[rd_ptr];

  always_comb begin
    push_entry         = '0;
    push_entry.itype   = bus.push_instr_type;
    push_entry.arith   = bus.push_arith_instr;
    push_entry.ram     = bus.push_ram_instr;
    push_entry.ldst    = bus.push_ld_st_instr;
    push_entry.cache   = bus.push_cache_addr;
    push_entry.main    = bus.push_main_mem_addr;
    push_entry.d_cache = bus.push_d_cache_addr;
    push_entry.d_main  = bus.push_d_main_mem_addr;
    push_entry.copies  = clamp_copies(bus.push_copies);
  end

  always_comb begin
    sel_ready = 1'b0;
    case (iss_type)
      2'd0:    sel_ready = bus.ldst_ready;
      2'd1:    sel_ready = bus.ram_ready;
      2'd2:    sel_ready = bus.arith_ready;
      default: sel_ready = 1'b0;
    endcase
  end

  assign sel_valid = (state == S_ISSUE);
  assign handshake = sel_valid && sel_ready;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_EMPTY;
    else       state <= state_next;
  end

  // Next state plus the pop/step strobes that drive the datapath.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    step       = 1'b0;
    case (state)
      S_EMPTY: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (handshake) begin
          if (iss_remaining > 4'd1) begin
            step = 1'b1;
          end else if (count != '0) begin
            pop = 1'b1;
          end else begin
            state_next = S_EMPTY;
          end
        end
      end
      default: state_next = S_EMPTY;
    endcase
  end

  always_comb begin
    bus.ldst_valid  = 1'b0;
    bus.ram_valid   = 1'b0;
    bus.arith_valid = 1'b0;
    if (sel_valid) begin
      case (iss_type)
        2'd0:    bus.ldst_valid  = 1'b1;
        2'd1:    bus.ram_valid   = 1'b1;
        2'd2:    bus.arith_valid = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    count_next = count;
    case ({push_acc, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      count                 <= '0;
      bus.queue_full        <= 1'b0;
      bus.queue_empty       <= 1'b1;
      bus.overflow          <= 1'b0;
      bus.idle              <= 1'b1;
      iss_type              <= 2'd0;
      iss_remaining         <= 4'd0;
      iss_d_cache           <= '0;
      iss_d_main            <= '0;
      bus.ldst_instr        <= '0;
      bus.ldst_cache_addr   <= '0;
      bus.ram_instr         <= '0;
      bus.ram_cache_addr    <= '0;
      bus.ram_main_mem_addr <= '0;
      bus.arith_instr       <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      count           <= count_next;
      bus.queue_full  <= (count_next == CW'(DEPTH));
      bus.queue_empty <= (count_next == '0);
      // A pop in the same cycle does not make room for a push that saw the queue full.
      if (bus.push_we && bus.queue_full) bus.overflow <= 1'b1;
      bus.idle        <= (count_next == '0) && (state_next == S_EMPTY);

      if (pop) begin
        iss_type      <= head.itype;
        iss_remaining <= head.copies;
        iss_d_cache   <= head.d_cache;
        iss_d_main    <= head.d_main;
        // Only the selected unit's outputs are refreshed; the others keep their last values.
        case (head.itype)
          2'd0: begin
            bus.ldst_instr      <= head.ldst;
            bus.ldst_cache_addr <= head.cache;
          end
          2'd1: begin
            bus.ram_instr         <= head.ram;
            bus.ram_cache_addr    <= head.cache;
            bus.ram_main_mem_addr <= head.main;
          end
          2'd2: bus.arith_instr <= head.arith;
          default: ;
        endcase
      end else if (step) begin
        iss_remaining <= iss_remaining - 4'd1;
        case (iss_type)
          2'd0: bus.ldst_cache_addr <= bus.ldst_cache_addr + iss_d_cache;
          2'd1: begin
            bus.ram_cache_addr    <= bus.ram_cache_addr + iss_d_cache;
            bus.ram_main_mem_addr <= bus.ram_main_mem_addr + iss_d_main;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (handshake)              stat_issued       <= stat_issued + 32'd1;
      if (sel_valid && !sel_ready) stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_dispatch.sv
// Bench for instr_dispatch: directed pushes feed an expected-issue queue that a negedge monitor checks.
// Covers reset, copy expansion, backpressure, overflow/wrap, mixed streams and reset mid-issue.
module tb_instr_dispatch;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;
`ifdef DISPATCH_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_stall_cycles;
`endif

  instr_dispatch_if bus ();

  always #5 clk = ~clk;

  instr_dispatch #(.DEPTH(DEPTH), .MAX_COPIES(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .dbg_state        (dbg_state)
`ifdef DISPATCH_STATS_EN
    ,
    .stat_issued      (stat_issued),
    .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  logic [51:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  function automatic logic [51:0] pack(input logic [1:0] unit, input logic [13:0] instr,
                                       input logic [17:0] cache, input logic [17:0] main);
    return {unit, instr, cache, main};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whatever the DUT presents with the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      int nv;
      logic [51:0] act;
      logic hs;
      nv  = int'(bus.ldst_valid) + int'(bus.ram_valid) + int'(bus.arith_valid);
      act = '0;
      hs  = 1'b0;
      if (bus.ldst_valid) begin
        act = pack(2'd0, 14'(bus.ldst_instr), bus.ldst_cache_addr, 18'd0);
        hs  = bus.ldst_ready;
      end else if (bus.ram_valid) begin
        act = pack(2'd1, 14'(bus.ram_instr), bus.ram_cache_addr, bus.ram_main_mem_addr);
        hs  = bus.ram_ready;
      end else if (bus.arith_valid) begin
        act = pack(2'd2, bus.arith_instr, 18'd0, 18'd0);
        hs  = bus.arith_ready;
      end
      if (nv > 0) begin
        check("one_hot_valid", 64'(nv), 64'd1);
        if (exp_q.size() == 0) begin
          if (hs) begin
            tests++;
            fails++;
            $display("FAIL unexpected_handshake actual=%0h required=none", act);
          end
        end else begin
          check("issue_payload", 64'(act), 64'(exp_q[0]));
          if (hs) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_push(input logic [1:0] t, input logic [13:0] a, input logic [8:0] r,
                         input logic [9:0] l, input logic [17:0] c, input logic [17:0] m,
                         input logic [17:0] dc, input logic [17:0] dm, input logic [3:0] cp,
                         input bit accept);
    int n;
    logic [17:0] cc;
    logic [17:0] mm;
    bus.push_we              = 1'b1;
    bus.push_instr_type      = t;
    bus.push_arith_instr     = a;
    bus.push_ram_instr       = r;
    bus.push_ld_st_instr     = l;
    bus.push_cache_addr      = c;
    bus.push_main_mem_addr   = m;
    bus.push_d_cache_addr    = dc;
    bus.push_d_main_mem_addr = dm;
    bus.push_copies          = cp;
    if (accept && t != 2'd3) begin
      n  = (cp == 4'd0) ? 1 : ((cp > 4'd8) ? 8 : int'(cp));
      cc = c;
      mm = m;
      for (int i = 0; i < n; i++) begin
        case (t)
          2'd0:    exp_q.push_back(pack(2'd0, 14'(l), cc, 18'd0));
          2'd1:    exp_q.push_back(pack(2'd1, 14'(r), cc, mm));
          default: exp_q.push_back(pack(2'd2, a, 18'd0, 18'd0));
        endcase
        cc = cc + dc;
        mm = mm + dm;
      end
    end
    tick();
    bus.push_we = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(bus.idle && exp_q.size() == 0) && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(bus.idle && exp_q.size() == 0), 64'd1);
  endtask

  initial begin
    int n;
    reset                    = 1'b1;
    bus.push_we              = 1'b0;
    bus.push_instr_type      = 2'd0;
    bus.push_arith_instr     = '0;
    bus.push_ram_instr       = '0;
    bus.push_ld_st_instr     = '0;
    bus.push_cache_addr      = '0;
    bus.push_main_mem_addr   = '0;
    bus.push_d_cache_addr    = '0;
    bus.push_d_main_mem_addr = '0;
    bus.push_copies          = '0;
    bus.ldst_ready           = 1'b0;
    bus.ram_ready            = 1'b0;
    bus.arith_ready          = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_ldst_valid", 64'(bus.ldst_valid), 64'd0);
    check("rst_ram_valid", 64'(bus.ram_valid), 64'd0);
    check("rst_arith_valid", 64'(bus.arith_valid), 64'd0);
    check("rst_queue_empty", 64'(bus.queue_empty), 64'd1);
    check("rst_queue_full", 64'(bus.queue_full), 64'd0);
    check("rst_idle", 64'(bus.idle), 64'd1);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_ldst_addr", 64'(bus.ldst_cache_addr), 64'd0);

    // Load/store, 4 copies stepping by 0x10
    bus.ldst_ready = 1'b1;
    do_push(2'd0, 14'd0, 9'd0, 10'h155, 18'h00100, 18'd0, 18'h00010, 18'd0, 4'd4, 1'b1);
    check("push_valid_early", 64'(bus.ldst_valid), 64'd0);
    tick();
    check("push_to_valid", 64'(bus.ldst_valid), 64'd1);
    n = 1;
    while (!bus.idle && n < 20) begin
      tick();
      n++;
    end
    check("ldst_idle_latency", 64'(n), 64'd5);
    check("ldst_drained", 64'(exp_q.size()), 64'd0);

    // RAM with backpressure and main address wrap
    bus.ram_ready = 1'b0;
    do_push(2'd1, 14'd0, 9'h1A5, 10'd0, 18'h00050, 18'h3FFFF, 18'h00004, 18'h00001, 4'd2, 1'b1);
    repeat (4) tick();
    check("ram_stall_valid", 64'(bus.ram_valid), 64'd1);
    check("ram_stall_pending", 64'(exp_q.size()), 64'd2);
    bus.ram_ready = 1'b1;
    wait_idle("ram_drain", 20);

    // Overflow: fill FIFO plus issue register, then one more push
    bus.ldst_ready  = 1'b0;
    bus.ram_ready   = 1'b0;
    bus.arith_ready = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      logic [3:0] cp;
      cp = (k == 3) ? 4'd0 : ((k == 5) ? 4'd15 : 4'd1);
      do_push((k % 2 == 1) ? 2'd0 : 2'd2, 14'(k + 1), 9'd0, 10'(k + 1), 18'(k * 16),
              18'd0, 18'h00002, 18'd0, cp, k < DEPTH + 1);
      if (k == DEPTH - 1) check("not_full_at_depth", 64'(bus.queue_full), 64'd0);
      if (k == DEPTH) begin
        check("full_at_depth_plus1", 64'(bus.queue_full), 64'd1);
        check("no_overflow_yet", 64'(bus.overflow), 64'd0);
      end
    end
    check("overflow_set", 64'(bus.overflow), 64'd1);
    check("full_after_overflow", 64'(bus.queue_full), 64'd1);
    bus.ldst_ready  = 1'b1;
    bus.ram_ready   = 1'b1;
    bus.arith_ready = 1'b1;
    wait_idle("overflow_drain", 300);
    check("overflow_sticky", 64'(bus.overflow), 64'd1);
    check("drain_empty", 64'(bus.queue_empty), 64'd1);

    // Mixed stream with a discarded loop push; negative cache delta
    do_push(2'd2, 14'h2ABC, 9'd0, 10'd0, 18'd0, 18'd0, 18'd0, 18'd0, 4'd1, 1'b1);
    do_push(2'd0, 14'd0, 9'd0, 10'h3C1, 18'h20000, 18'd0, 18'h3FFFF, 18'd0, 4'd3, 1'b1);
    do_push(2'd3, 14'h1111, 9'h111, 10'h111, 18'h11111, 18'h11111, 18'd1, 18'd1, 4'd2, 1'b1);
    do_push(2'd1, 14'd0, 9'h0F0, 10'd0, 18'h00001, 18'h00002, 18'd0, 18'd0, 4'd1, 1'b1);
    n = 0;
    while (!bus.idle && n < 20) begin
      tick();
      n++;
    end
    check("mixed_latency", 64'(n), 64'd3);
    check("mixed_drained", 64'(exp_q.size()), 64'd0);

    // Reset while copy 2 of 4 is stalled
    do_push(2'd0, 14'd0, 9'd0, 10'h2AA, 18'h01000, 18'd0, 18'h00008, 18'd0, 4'd4, 1'b1);
    tick();
    tick();
    bus.ldst_ready = 1'b0;
    check("mid_copies_left", 64'(exp_q.size()), 64'd3);
    tick();
    exp_q.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.ldst_ready = 1'b1;
    check("mid_rst_valid", 64'(bus.ldst_valid), 64'd0);
    check("mid_rst_empty", 64'(bus.queue_empty), 64'd1);
    check("mid_rst_idle", 64'(bus.idle), 64'd1);
    check("mid_rst_overflow", 64'(bus.overflow), 64'd0);
    repeat (6) tick();
    check("mid_rst_quiet", 64'(bus.ldst_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_dispatch.md
# instr_dispatch

Instruction queue and dispatcher between the control unit and the execution units. Buffers control-unit pushes in a FIFO, then issues them strictly in order, one per cycle, to the load/store, RAM (DMA) or arithmetic unit over valid/ready handshakes. Each queue entry carries a copy count, so one push from an independent loop expands into up to 8 back-to-back issues. Address fields step by their per-copy delta on every copy.

## Interface
- DEPTH, 16, FIFO entries; power of two, at least 2.
- MAX_COPIES, 8, largest legal copy count.

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- push_we  in  1  push strobe from control unit
- push_instr_type  in  2  0 load/store, 1 RAM, 2 arithmetic, 3 loop
- push_arith_instr  in  14  arithmetic payload
- push_ram_instr  in  9  RAM payload
- push_ld_st_instr  in  10  load/store payload
- push_cache_addr, push_main_mem_addr  in  18 each  first-copy addresses
- push_d_cache_addr, push_d_main_mem_addr  in  18 each  per-copy address deltas
- push_copies  in  4  copy count; 0 is treated as 1; values above MAX_COPIES are clamped
- queue_full  out  1  registered; FIFO holds DEPTH entries
- queue_empty  out  1  registered; FIFO holds 0 entries
- overflow  out  1  sticky; set when push_we arrives while queue_full
- idle  out  1  FIFO empty and no copy pending
- ldst_valid out 1, ldst_ready in 1, ldst_instr out 10, ldst_cache_addr out 18
- ram_valid out 1, ram_ready in 1, ram_instr out 9, ram_cache_addr out 18, ram_main_mem_addr out 18
- arith_valid out 1, arith_ready in 1, arith_instr out 14

## Operation
- **Push accept**
  - A push is accepted when push_we=1, queue_full=0 and type≠3.
  - Type 3 (loop) pushes are silently discarded.
  - A push while full is dropped and sets overflow. A pop in the same cycle does not rescue it.
- **FIFO**
  - Circular buffer with DEPTH-wrapping read/write pointers and a count register.
  - full/empty are computed from the next count and registered.
- **Issue register**: one entry plus a remaining-copy counter. States:
  - EMPTY: loads the FIFO head when the FIFO is non-empty, then → ISSUE.
  - ISSUE: exactly one of ldst/ram/arith_valid=1, selected by the stored type.
- **Handshake** (selected valid & ready):
  - If remaining>1: remaining−1, cache_addr += d_cache_addr, main_mem_addr += d_main_mem_addr. Sums are unsigned mod 2^18, so negative deltas work in two's complement.
  - If remaining==1: load the next FIFO head in the same edge and stay in ISSUE. If the FIFO is empty → EMPTY.
- **Stall**: while valid & !ready, all payload and address outputs hold stable.
- **Unused outputs**: payload/address outputs of non-selected units hold their last value; only the valids matter.
- **Arithmetic copies**: issue the same payload repeatedly.
- **Reset values**: all valids 0, queue_empty 1, queue_full 0, overflow 0, idle 1, pointers/count 0, all payload/address outputs 0. Reset mid-issue discards all entries and pending copies with no further handshakes.

## Timing
- **Push to issue**: push at edge N → entry in FIFO after N → issue register loaded at N+1 → valid high in the cycle after N+1 (2-edge latency from an idle start).
- **Throughput**: 1 issue per cycle sustained across entry boundaries, with no bubble between the last copy of one entry and the next entry.
- **Simultaneous push and head pop**: count unchanged; full/empty reflect the net count.
- **Push at edge N onto an empty FIFO while the issue register is finishing its last copy**: the entry loads at edge N+1, leaving one bubble cycle.
- **Wrap-around**: pointers wrap at DEPTH. Entry order is preserved across the wrap.
- **idle**: registered; goes high the cycle after the last handshake when the FIFO is empty.

## Configuration
- **DISPATCH_STATS_EN defined**: adds outputs stat_issued (32, counts every handshake) and stat_stall_cycles (32, counts cycles with a valid high and its ready low). Both reset to 0 and wrap at 2^32.
- **Not defined**: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- **Reset**: reset for 2 cycles → all valids 0, queue_empty=1, idle=1, overflow=0.
- **Load/store copies**: type0 push, copies=4, cache_addr=0x100, d_cache=0x10, ldst_ready=1 → ldst_valid for 4 consecutive cycles with addresses 0x100, 0x110, 0x120, 0x130, then idle=1.
- **RAM with backpressure**: type1 push, copies=2, main=0x3FFFF, d_main=1, ram_ready low for 3 cycles → payload stable during the stall; issued main addresses are 0x3FFFF then 0x00000 (wraps).
- **Overflow**: DEPTH+1 pushes with all readies low → queue_full after DEPTH+1 cycles in total (one entry is already in the issue register), overflow=1; later all entries drain in push order.
- **Mixed stream**: arith(copies=1), ldst(copies=3), loop, ram(copies=1), all readies high → 5 handshakes on consecutive cycles, in order arith, ldst×3, ram; the loop push never appears.
- **Reset mid-issue**: reset asserted mid-copy (copy 2 of 4) → valid drops the next cycle, FIFO empty, no further handshakes.
